trap_ctrl: RTL

Machine-mode trap and PC-redirect controller for the RV32I_Zicsr pipeline. It arbitrates every PC redirect source in the execute stage: synchronous exceptions, external and timer interrupts, MRET and taken branches/jumps. For traps it sequences stall, flush, memory-stage drain, CSR update and redirect. It owns mepc, mcause, mtval and mstatus.MIE/MPIE, and drives the fetch-stage jump and the pipeline stall/flush lines.

---
 rtl/trap_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//
// Machine-mode trap and PC-redirect controller for the RV32I_Zicsr pipeline.
// It arbitrates all redirect sources seen in execute. The sources are, in
// priority order:
//   - exception
//   - interrupt
//   - MRET
//   - taken branch/jump
//   - CSR write
// Only the highest-priority event acts in a cycle.
//
// A trap takes the controller through three steps:
//   - DRAIN: hold the pipeline stalled and flushed until the memory stage
//     goes idle.
//   - ENTER: redirect fetch to the trap vector for one cycle.
//   - Back to IDLE: mepc, mcause, mtval and mstatus.MIE/MPIE take their new
//     values as the controller leaves ENTER.
//
// Ports
//   Clock and reset:
//     i_clk, i_rst          clock, synchronous active-high reset
//   Trap sources:
//     i_exc_*               exception valid/cause/pc/tval from execute
//     i_irq, i_irq_en       {timer, external} pending lines and their enables
//   Execute stage:
//     i_ex_valid, i_ex_pc   execute holds a real instruction / its PC
//     i_mret                MRET in execute
//     i_branch_jump         taken branch or jump in execute
//     i_branch_pc           target of that branch or jump
//   Memory stage and CSRs:
//     i_mem_busy            memory stage has a load/store in flight
//     i_mtvec               mtvec CSR value
//     i_csr_*               CSR write port from execute
//   Pipeline control (all registered):
//     or_stall, or_flush    stall all upstream stages / squash IF/ID/EX
//     or_pc_jump            one-cycle redirect strobe to fetch
//     or_pc_next            redirect target
//   CSR read values (all registered):
//     or_mepc, or_mcause, or_mtval, or_mstatus_mie, or_mstatus_mpie
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_exc_valid,
  input  logic [3:0]      i_exc_cause,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic [XLEN-1:0] i_exc_tval,
  input  logic [1:0]      i_irq,
  input  logic [1:0]      i_irq_en,
  input  logic            i_ex_valid,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic            i_mret,
  input  logic            i_branch_jump,
  input  logic [XLEN-1:0] i_branch_pc,
  input  logic            i_mem_busy,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic            i_csr_we,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic            or_stall,
  output logic            or_flush,
  output logic            or_pc_jump,
  output logic [XLEN-1:0] or_pc_next,
  output logic [XLEN-1:0] or_mepc,
  output logic [XLEN-1:0] or_mcause,
  output logic [XLEN-1:0] or_mtval,
  output logic            or_mstatus_mie,
  output logic            or_mstatus_mpie
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_ENTER = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] CAUSE_EXT_IRQ   = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
  localparam logic [XLEN-1:0] CAUSE_TIMER_IRQ = {1'b1, {(XLEN-5){1'b0}}, 4'd7};

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Trap vector.
  // mtvec mode 01 vectors interrupts to base + 4*code. Every other mode, and
  // every exception, goes straight to base.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input logic            is_irq,
                                                  input logic [3:0]      code);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (is_irq && (mtvec[1:0] == 2'b01)) begin
      trap_target = base + {{(XLEN-6){1'b0}}, code, 2'b00};
    end else begin
      trap_target = base;
    end
  endfunction

  state_t          r_state;
  logic [XLEN-1:0] r_cause;    // cause of the trap being taken
  logic [XLEN-1:0] r_epc;      // return PC of the trap being taken
  logic [XLEN-1:0] r_tval;     // trap value of the trap being taken
  logic            r_is_irq;   // trap being taken is an interrupt

  logic [1:0]      w_irq_act;
  logic            w_irq_take;
  logic [XLEN-1:0] w_irq_cause;
  logic [XLEN-1:0] w_trap_pc;
  logic            w_unused;

  // Interrupt qualification, external-first cause selection and vector target.
  always_comb begin
    w_irq_act   = i_irq & i_irq_en;
    w_irq_take  = or_mstatus_mie & (|w_irq_act) & i_ex_valid;
    w_irq_cause = w_irq_act[0] ? CAUSE_EXT_IRQ : CAUSE_TIMER_IRQ;
    w_trap_pc   = trap_target(i_mtvec, r_is_irq, r_cause[3:0]);
    w_unused    = ^RESET_VEC;
  end

  // Controller state, trap latch, CSRs and registered pipeline controls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_cause         <= '0;
      r_epc           <= '0;
      r_tval          <= '0;
      r_is_irq        <= 1'b0;
      or_stall        <= 1'b0;
      or_flush        <= 1'b0;
      or_pc_jump      <= 1'b0;
      or_pc_next      <= '0;
      or_mepc         <= '0;
      or_mcause       <= '0;
      or_mtval        <= '0;
      or_mstatus_mie  <= 1'b0;
      or_mstatus_mpie <= 1'b0;
    end else begin
      // Strobes default low; each branch below raises only what it needs.
      or_stall   <= 1'b0;
      or_flush   <= 1'b0;
      or_pc_jump <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_exc_valid) begin
            r_cause  <= {{(XLEN-4){1'b0}}, i_exc_cause};
            r_epc    <= i_exc_pc;
            r_tval   <= i_exc_tval;
            r_is_irq <= 1'b0;
            r_state  <= S_DRAIN;
            or_stall <= 1'b1;
            or_flush <= 1'b1;
          end else if (w_irq_take) begin
            // The instruction in execute is squashed and re-executed after
            // MRET, so its own PC becomes the return address.
            r_cause  <= w_irq_cause;
            r_epc    <= i_ex_pc;
            r_tval   <= '0;
            r_is_irq <= 1'b1;
            r_state  <= S_DRAIN;
            or_stall <= 1'b1;
            or_flush <= 1'b1;
          end else if (i_mret) begin
            or_pc_jump      <= 1'b1;
            or_pc_next      <= or_mepc;
            or_flush        <= 1'b1;
            or_mstatus_mie  <= or_mstatus_mpie;
            or_mstatus_mpie <= 1'b1;
          end else if (i_branch_jump) begin
            or_pc_jump <= 1'b1;
            or_pc_next <= i_branch_pc;
            or_flush   <= 1'b1;
          end else if (i_csr_we) begin
            case (i_csr_addr)
              CSR_MSTATUS: begin
                or_mstatus_mie  <= i_csr_wdata[3];
                or_mstatus_mpie <= i_csr_wdata[7];
              end
              CSR_MEPC:   or_mepc   <= {i_csr_wdata[XLEN-1:2], 2'b00};
              CSR_MCAUSE: or_mcause <= i_csr_wdata;
              CSR_MTVAL:  or_mtval  <= i_csr_wdata;
              default:    ;
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // Stall and flush stay high for the whole drain and for ENTER.
          or_stall <= 1'b1;
          or_flush <= 1'b1;
          if (!i_mem_busy) begin
            r_state    <= S_ENTER;
            or_pc_jump <= 1'b1;
            or_pc_next <= w_trap_pc;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_ENTER: begin
          // Leaving ENTER commits the trap to the CSRs.
          or_mepc         <= {r_epc[XLEN-1:2], 2'b00};
          or_mcause       <= r_cause;
          or_mtval        <= r_tval;
          or_mstatus_mpie <= or_mstatus_mie;
          or_mstatus_mie  <= 1'b0;
          r_state         <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
